column_fifo_bridge: RTL and testbench

Memory-bus bridge between the `cpu` memory port and the main synchronous block RAM. It passes ordinary loads and stores straight through to RAM. It also decodes two memory-mapped addresses:
- a push port that queues 16-bit column words, as produced by the CPU's raycast loop, into a FIFO drained by the display side;
- a status register the CPU polls before pushing.

It sits directly downstream of the CPU's `memory_*` bus.

---
 rtl/column_bridge_pkg.sv | 22 ++
 rtl/column_fifo.sv | 62 ++++++
 rtl/column_fifo_bridge.sv | 112 +++++++++++
 tb/tb_column_fifo_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/column_bridge_pkg.sv
// Shared constants and the status-word layout for the column FIFO bridge.
package column_bridge_pkg;

  localparam logic [15:0] FIFO_ADDR_DEFAULT   = 16'hFFF0;
  localparam logic [15:0] STATUS_ADDR_DEFAULT = 16'hFFF1;

  localparam int STATUS_FULL_BIT     = 15;
  localparam int STATUS_EMPTY_BIT    = 14;
  localparam int STATUS_OVERFLOW_BIT = 13;

  typedef struct packed {
    logic       full;
    logic       empty;
    logic       overflow;
    logic [4:0] rsvd;
    logic [7:0] count;
  } status_t;

  localparam status_t STATUS_RESET = '{full: 1'b0, empty: 1'b1, overflow: 1'b0,
                                       rsvd: 5'd0, count: 8'd0};

endpackage

// File: rtl/column_fifo.sv
// Flop-based FIFO holding column words; a push while full is accepted only
// when a pop frees a slot on the same edge.
module column_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so column_data reads 0 out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/column_fifo_bridge.sv
// CPU-to-RAM bridge with a memory-mapped column push port and status register.
// Optional sticky overflow tracking: COLUMN_FIFO_BRIDGE_OVERFLOW_EN.
module column_fifo_bridge
  import column_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] FIFO_ADDR   = FIFO_ADDR_DEFAULT,
  parameter logic [15:0] STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_memory_address,
  input  logic        cpu_memory_write_enable,
  input  logic [15:0] cpu_memory_write_data,
  output logic [15:0] cpu_memory_read_data,
  output logic [15:0] ram_address,
  output logic        ram_write_enable,
  output logic [15:0] ram_write_data,
  input  logic [15:0] ram_read_data,
  output logic [15:0] column_data,
  output logic        column_valid,
  input  logic        column_ready,
  output logic        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          hit_fifo, hit_status;
  logic          push_req, pop_req;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          overflow_q;
  logic          sel_status_q, sel_status_d;
  status_t       status_now, status_snap_q, status_snap_d;

  assign hit_fifo   = (cpu_memory_address == FIFO_ADDR);
  assign hit_status = (cpu_memory_address == STATUS_ADDR);

  assign ram_address      = cpu_memory_address;
  assign ram_write_data   = cpu_memory_write_data;
  assign ram_write_enable = cpu_memory_write_enable && !(hit_fifo || hit_status);

  assign push_req     = cpu_memory_write_enable && hit_fifo;
  assign pop_req      = column_valid && column_ready;
  assign column_valid = !fifo_empty;

  column_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (push_req),
    .push_data_i (cpu_memory_write_data),
    .pop_i       (pop_req),
    .head_o      (column_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef COLUMN_FIFO_BRIDGE_OVERFLOW_EN
  logic overflow_d;
  logic drop;

  // A push while full survives only if a pop frees a slot on the same edge.
  assign drop = push_req && fifo_full && !pop_req;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (cpu_memory_write_enable && hit_status &&
             cpu_memory_write_data[STATUS_OVERFLOW_BIT])
      overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end
`else
  assign overflow_q = 1'b0;
`endif

  assign overflow = overflow_q;

  always_comb begin
    status_now          = '0;
    status_now.full     = fifo_full;
    status_now.empty    = fifo_empty;
    status_now.overflow = overflow_q;
    status_now.count    = 8'(fifo_count);
    sel_status_d        = hit_status;
    status_snap_d       = status_now;
  end

  // Snapshot is taken before this edge's push/pop so a status load sees
  // the FIFO as it stood when the address was presented.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel_status_q  <= 1'b0;
      status_snap_q <= STATUS_RESET;
    end else begin
      sel_status_q  <= sel_status_d;
      status_snap_q <= status_snap_d;
    end
  end

  assign cpu_memory_read_data = sel_status_q ? status_snap_q : ram_read_data;

endmodule

// File: tb/tb_column_fifo_bridge.sv
// Directed self-checking bench for column_fifo_bridge with a column-word scoreboard.
module tb_column_fifo_bridge;

  localparam int          DEPTH  = 16;
  localparam logic [15:0] F_ADDR = 16'hFFF0;
  localparam logic [15:0] S_ADDR = 16'hFFF1;
`ifdef COLUMN_FIFO_BRIDGE_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_memory_address = 16'h0000;
  logic        cpu_memory_write_enable = 1'b0;
  logic [15:0] cpu_memory_write_data = 16'h0000;
  logic [15:0] cpu_memory_read_data;
  logic [15:0] ram_address;
  logic        ram_write_enable;
  logic [15:0] ram_write_data;
  logic [15:0] ram_read_data = 16'h0000;
  logic [15:0] column_data;
  logic        column_valid;
  logic        column_ready = 1'b0;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        model_ovf = 1'b0;
  logic [15:0] ram_mem [256];
  int          ram_wr_count = 0;
  int          ram_wr_before;

  column_fifo_bridge #(
    .FIFO_DEPTH  (DEPTH),
    .FIFO_ADDR   (F_ADDR),
    .STATUS_ADDR (S_ADDR)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .cpu_memory_address      (cpu_memory_address),
    .cpu_memory_write_enable (cpu_memory_write_enable),
    .cpu_memory_write_data   (cpu_memory_write_data),
    .cpu_memory_read_data    (cpu_memory_read_data),
    .ram_address             (ram_address),
    .ram_write_enable        (ram_write_enable),
    .ram_write_data          (ram_write_data),
    .ram_read_data           (ram_read_data),
    .column_data             (column_data),
    .column_valid            (column_valid),
    .column_ready            (column_ready),
    .overflow                (overflow)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;

  always @(posedge clock) begin
    if (ram_write_enable) begin
      ram_mem[ram_address[7:0]] <= ram_write_data;
      ram_wr_count <= ram_wr_count + 1;
    end
    ram_read_data <= ram_mem[ram_address[7:0]];
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    return {exp_q.size() == DEPTH, exp_q.size() == 0, model_ovf, 5'b0, 8'(exp_q.size())};
  endfunction

  // Scores any pop that the coming edge will perform, then advances one cycle.
  task automatic step();
    if (column_valid === 1'b1 && column_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed %h expected no word", column_data);
      end
      if (exp_q.size() != 0) check16("drain_order", column_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    bit accept;
    cpu_memory_address      = F_ADDR;
    cpu_memory_write_enable = 1'b1;
    cpu_memory_write_data   = d;
    #1;
    check16("push_no_ram_we", {15'b0, ram_write_enable}, 16'h0000);
    accept = (exp_q.size() < DEPTH) || (column_ready && exp_q.size() > 0);
    if (!accept && OVF_EN) model_ovf = 1'b1;
    step();
    if (accept) exp_q.push_back(d);
    cpu_memory_write_enable = 1'b0;
    cpu_memory_address      = 16'h0000;
  endtask

  task automatic read_status(input string tag);
    logic [15:0] e;
    e = model_status();
    cpu_memory_address      = S_ADDR;
    cpu_memory_write_enable = 1'b0;
    step();
    check16(tag, cpu_memory_read_data, e);
    cpu_memory_address = 16'h0000;
  endtask

  task automatic drain(input string tag);
    column_ready = 1'b1;
    for (int k = 0; k < 4 * DEPTH && exp_q.size() > 0; k++) step();
    column_ready = 1'b0;
    #1;
    check16(tag, {15'b0, column_valid}, 16'h0000);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    step();
    step();
    check16("reset_valid", {15'b0, column_valid}, 16'h0000);
    check16("reset_data", column_data, 16'h0000);
    check16("reset_overflow", {15'b0, overflow}, 16'h0000);
    reset = 1'b1;
    read_status("reset_status");
    check16("reset_status_const", cpu_memory_read_data, 16'h4000);

    // RAM pass-through
    cpu_memory_address      = 16'h0010;
    cpu_memory_write_enable = 1'b1;
    cpu_memory_write_data   = 16'h1234;
    #1;
    check16("ram_we", {15'b0, ram_write_enable}, 16'h0001);
    check16("ram_addr", ram_address, 16'h0010);
    check16("ram_wdata", ram_write_data, 16'h1234);
    step();
    cpu_memory_write_enable = 1'b0;
    step();
    check16("ram_load", cpu_memory_read_data, 16'h1234);

    // Push/pop
    column_ready = 1'b0;
    push(16'hA001);
    check16("push_valid_latency", {15'b0, column_valid}, 16'h0001);
    check16("push_head", column_data, 16'hA001);
    push(16'hA002);
    check16("head_held", column_data, 16'hA001);
    read_status("status_count2");
    drain("pushpop_empty");

    // Fill and overflow
    ram_wr_before = ram_wr_count;
    for (int i = 0; i < DEPTH + 1; i++) push(16'hC000 + 16'(i));
    read_status("full_status");
    check16("overflow_flag", {15'b0, overflow}, {15'b0, model_ovf});
    check16("fill_no_ram_write", 16'(ram_wr_count - ram_wr_before), 16'h0000);
    cpu_memory_address      = S_ADDR;
    cpu_memory_write_enable = 1'b1;
    cpu_memory_write_data   = 16'h2000;
    #1;
    check16("status_store_no_ram", {15'b0, ram_write_enable}, 16'h0000);
    step();
    cpu_memory_write_enable = 1'b0;
    model_ovf = 1'b0;
    check16("overflow_cleared", {15'b0, overflow}, 16'h0000);
    read_status("status_after_clear");

    // Full with simultaneous pop and push
    column_ready = 1'b1;
    push(16'hBEEF);
    column_ready = 1'b0;
    read_status("full_pushpop_count");
    check16("beef_last", exp_q[DEPTH-1], 16'hBEEF);
    drain("full_drain_empty");

    // Pointer wrap
    column_ready = 1'b1;
    for (int i = 0; i < 40; i++) push(16'h5000 + 16'(i));
    drain("wrap_empty");

    // Load from push port must not pop
    for (int i = 0; i < 3; i++) push(16'h5A00 + 16'(i));
    cpu_memory_address = F_ADDR;
    step();
    read_status("fifo_load_no_pop");

    // Reset mid-stream
    for (int i = 3; i < 5; i++) push(16'h5A00 + 16'(i));
    read_status("five_queued");
    reset = 1'b0;
    step();
    exp_q.delete();
    model_ovf = 1'b0;
    check16("midreset_valid", {15'b0, column_valid}, 16'h0000);
    check16("midreset_data", column_data, 16'h0000);
    reset = 1'b1;
    read_status("midreset_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
